// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one line-wide memory port between an i_cache (read-only) and a d_cache
// (read/write): one transaction at a time, round-robin on conflict, sticky timeout flag.
module mem_port_arbiter #(
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_SIZE  = 20,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_SIZE-1:0]  i_cache_address,
  input  logic                  i_cache_enable,
  output logic [LINE_WIDTH-1:0] i_cache_out_data,
  output logic                  i_cache_ready,
  input  logic [ADDR_SIZE-1:0]  d_cache_address,
  input  logic [LINE_WIDTH-1:0] d_cache_in_data,
  input  logic                  d_cache_write_or_read,
  input  logic                  d_cache_enable,
  output logic [LINE_WIDTH-1:0] d_cache_out_data,
  output logic                  d_cache_ready,
  output logic [ADDR_SIZE-1:0]  mem_address,
  output logic [LINE_WIDTH-1:0] mem_in_data,
  output logic                  mem_write_or_read,
  output logic                  mem_enable,
  input  logic [LINE_WIDTH-1:0] mem_out_data,
  input  logic                  mem_ready,
  output logic                  timeout_error
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic       PORT_IC    = 1'b0;
  localparam logic       PORT_DC    = 1'b1;
  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  state_t                state;
  logic                  last_grant;
  logic                  winner;
  logic [7:0]            count;
  logic                  grant_dc;
  logic                  finish;
  logic [LINE_WIDTH-1:0] fill;

  // On a tie the port that did not win last time gets the grant.
  assign grant_dc = d_cache_enable && (!i_cache_enable || (last_grant == PORT_IC));
  // A timed-out transaction completes like a normal one carrying an all-zero line.
  assign finish   = mem_ready || (count == LAST_COUNT);
  assign fill     = mem_ready ? mem_out_data : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      last_grant        <= PORT_DC;
      winner            <= PORT_IC;
      count             <= '0;
      i_cache_out_data  <= '0;
      i_cache_ready     <= 1'b0;
      d_cache_out_data  <= '0;
      d_cache_ready     <= 1'b0;
      mem_address       <= '0;
      mem_in_data       <= '0;
      mem_write_or_read <= 1'b0;
      mem_enable        <= 1'b0;
      timeout_error     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_cache_enable || d_cache_enable) begin
            winner     <= grant_dc;
            last_grant <= grant_dc;
            if (grant_dc) begin
              mem_address       <= d_cache_address;
              mem_in_data       <= d_cache_in_data;
              mem_write_or_read <= d_cache_write_or_read;
            end else begin
              mem_address       <= i_cache_address;
              mem_in_data       <= '0;
              mem_write_or_read <= 1'b0;
            end
            mem_enable <= 1'b1;
            count      <= '0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          count <= count + 8'd1;
          if (finish) begin
            if (!mem_ready) timeout_error <= 1'b1;
            mem_enable <= 1'b0;
            if (!mem_write_or_read) begin
              if (winner == PORT_DC) d_cache_out_data <= fill;
              else                   i_cache_out_data <= fill;
            end
            if (winner == PORT_DC) d_cache_ready <= 1'b1;
            else                   i_cache_ready <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          i_cache_ready <= 1'b0;
          d_cache_ready <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table of single transactions against a
// small memory responder, plus hand sequences for fairness, stability, timeout and reset.
module tb_mem_port_arbiter;

  logic         clk;
  logic         reset;
  logic [19:0]  i_cache_address;
  logic         i_cache_enable;
  logic [127:0] i_cache_out_data;
  logic         i_cache_ready;
  logic [19:0]  d_cache_address;
  logic [127:0] d_cache_in_data;
  logic         d_cache_write_or_read;
  logic         d_cache_enable;
  logic [127:0] d_cache_out_data;
  logic         d_cache_ready;
  logic [19:0]  mem_address;
  logic [127:0] mem_in_data;
  logic         mem_write_or_read;
  logic         mem_enable;
  logic [127:0] mem_out_data;
  logic         mem_ready;
  logic         timeout_error;

  mem_port_arbiter #(.LINE_WIDTH(128), .ADDR_SIZE(20), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .i_cache_address(i_cache_address), .i_cache_enable(i_cache_enable),
    .i_cache_out_data(i_cache_out_data), .i_cache_ready(i_cache_ready),
    .d_cache_address(d_cache_address), .d_cache_in_data(d_cache_in_data),
    .d_cache_write_or_read(d_cache_write_or_read), .d_cache_enable(d_cache_enable),
    .d_cache_out_data(d_cache_out_data), .d_cache_ready(d_cache_ready),
    .mem_address(mem_address), .mem_in_data(mem_in_data),
    .mem_write_or_read(mem_write_or_read), .mem_enable(mem_enable),
    .mem_out_data(mem_out_data), .mem_ready(mem_ready), .timeout_error(timeout_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic         dc;        // 1 = d_cache requests, 0 = i_cache requests
    logic [19:0]  addr;
    logic [127:0] wdata;
    logic         we;
    int           lat;
    logic [127:0] resp;
    logic [127:0] exp_ic_out;
    logic [127:0] exp_dc_out;
  } vec_t;

  int total  = 0;
  int passed = 0;

  // Memory responder state (answers lat cycles after mem_enable rises; lat 0 = never).
  int           latency   = 1;
  logic [127:0] resp_data = '0;
  bit           active    = 0;
  int           cnt       = 0;
  int           en_cycles = 0;
  bit           mem_changed = 0;
  logic [19:0]  cap_addr;
  logic [127:0] cap_data;
  logic         cap_we;
  int           ic_pulses = 0;
  int           dc_pulses = 0;
  int           both_high = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  initial begin
    mem_ready    = 1'b0;
    mem_out_data = '0;
    forever begin
      @(negedge clk);
      if (i_cache_ready) ic_pulses++;
      if (d_cache_ready) dc_pulses++;
      if (i_cache_ready && d_cache_ready) both_high++;
      if (mem_enable) begin
        en_cycles++;
        if (!active) begin
          active   = 1;
          cnt      = 1;
          cap_addr = mem_address;
          cap_data = mem_in_data;
          cap_we   = mem_write_or_read;
        end else begin
          cnt++;
          if (mem_address !== cap_addr || mem_in_data !== cap_data ||
              mem_write_or_read !== cap_we) mem_changed = 1;
        end
        mem_ready    = (latency != 0) && (cnt == latency);
        mem_out_data = mem_ready ? resp_data : '0;
      end else begin
        active       = 0;
        cnt          = 0;
        mem_ready    = 1'b0;
        mem_out_data = '0;
      end
    end
  end

  function automatic vec_t mk(input logic dc, input logic [19:0] addr, input logic [127:0] wdata,
                              input logic we, input int lat, input logic [127:0] resp,
                              input logic [127:0] eic, input logic [127:0] edc);
    vec_t v;
    v.dc = dc; v.addr = addr; v.wdata = wdata; v.we = we; v.lat = lat; v.resp = resp;
    v.exp_ic_out = eic; v.exp_dc_out = edc;
    return v;
  endfunction

  task automatic wait_ready(input int limit, output int n);
    n = 0;
    while (n < limit) begin
      @(negedge clk);
      n++;
      if (i_cache_ready || d_cache_ready) break;
    end
  endtask

  // Called on a negedge with the arbiter idle; returns on a negedge with it idle again.
  task automatic run_txn(input string tag, input vec_t v);
    int n;
    latency     = v.lat;
    resp_data   = v.resp;
    mem_changed = 0;
    if (v.dc) begin
      d_cache_address = v.addr; d_cache_in_data = v.wdata;
      d_cache_write_or_read = v.we; d_cache_enable = 1'b1;
    end else begin
      i_cache_address = v.addr; i_cache_enable = 1'b1;
    end
    wait_ready(40, n);
    chk({tag, " ready_port"}, {126'd0, i_cache_ready, d_cache_ready}, {126'd0, !v.dc, v.dc});
    chk({tag, " latency"}, 128'(n), 128'(v.lat + 1));
    chk({tag, " ic_out"}, i_cache_out_data, v.exp_ic_out);
    chk({tag, " dc_out"}, d_cache_out_data, v.exp_dc_out);
    chk({tag, " mem_addr"}, 128'(cap_addr), 128'(v.addr));
    chk({tag, " mem_we"}, 128'(cap_we), 128'(v.dc && v.we));
    if (v.dc && v.we) chk({tag, " mem_wdata"}, cap_data, v.wdata);
    chk({tag, " mem_stable"}, 128'(mem_changed), 128'(0));
    chk({tag, " mem_en_low"}, 128'(mem_enable), 128'(0));
    i_cache_enable = 1'b0;
    d_cache_enable = 1'b0;
    @(negedge clk);
    chk({tag, " pulse_1cyc"}, {126'd0, i_cache_ready, d_cache_ready}, 128'(0));
    $display("txn %s: dc=%0d addr=%05h we=%0d lat=%0d done after %0d cycles",
             tag, v.dc, v.addr, v.we, v.lat, n);
  endtask

  localparam logic [127:0] LINE_A = {32{4'hA}};
  localparam logic [127:0] LINE_B = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] LINE_C = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;

  vec_t vecs[6];

  initial begin
    int n;
    int ic_before;
    int dc_before;
    logic got_dc;
    logic [19:0] exp_a;
    vec_t v;

    vecs[0] = mk(0, 20'h00010, '0, 0, 3, LINE_A, LINE_A, '0);
    vecs[1] = mk(1, 20'h00040, 128'h1234, 1, 1, LINE_C, LINE_A, '0);
    vecs[2] = mk(1, 20'h00123, '0, 0, 2, LINE_C, LINE_A, LINE_C);
    vecs[3] = mk(0, 20'hFFFFF, '0, 0, 1, LINE_B, LINE_B, LINE_C);
    vecs[4] = mk(1, 20'h00001, LINE_A, 1, 4, LINE_B, LINE_B, LINE_C);
    vecs[5] = mk(0, 20'h00000, '0, 0, 6, LINE_C, LINE_C, LINE_C);

    reset = 1'b0;
    i_cache_address = '0; i_cache_enable = 1'b0;
    d_cache_address = '0; d_cache_in_data = '0;
    d_cache_write_or_read = 1'b0; d_cache_enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset mem_enable", 128'(mem_enable), 128'(0));
    chk("reset outs", {i_cache_out_data | d_cache_out_data}, '0);
    chk("reset readies", {126'd0, i_cache_ready, d_cache_ready}, 128'(0));
    chk("reset timeout", 128'(timeout_error), 128'(0));
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_txn($sformatf("vec%0d", i), vecs[i]);
    chk("pulse count ic", 128'(ic_pulses), 128'(3));
    chk("pulse count dc", 128'(dc_pulses), 128'(3));

    // Fairness: both held from the same edge after reset, grants alternate IC, DC, IC, DC.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    latency = 1; resp_data = LINE_B;
    i_cache_address = 20'h00A00; d_cache_address = 20'h00B00;
    d_cache_write_or_read = 1'b0;
    i_cache_enable = 1'b1; d_cache_enable = 1'b1;
    for (int g = 0; g < 4; g++) begin
      wait_ready(40, n);
      got_dc = d_cache_ready;
      exp_a  = (g % 2 == 1) ? 20'h00B00 : 20'h00A00;
      chk($sformatf("fair grant%0d", g), 128'(got_dc), 128'(g % 2));
      chk($sformatf("fair addr%0d", g), 128'(cap_addr), 128'(exp_a));
      $display("txn fair%0d: winner=%s after %0d cycles", g, got_dc ? "dc" : "ic", n);
      if (got_dc) d_cache_enable = 1'b0; else i_cache_enable = 1'b0;
      if (g == 3) begin
        i_cache_enable = 1'b0; d_cache_enable = 1'b0;
      end
      @(negedge clk);
      if (g != 3) begin
        if (got_dc) d_cache_enable = 1'b1; else i_cache_enable = 1'b1;
      end
    end
    chk("fair both_ready", 128'(both_high), 128'(0));
    @(negedge clk);

    // Requester address changes mid-transaction; the memory keeps the latched one.
    latency = 5; resp_data = LINE_A; mem_changed = 0;
    d_cache_address = 20'h00200; d_cache_write_or_read = 1'b0; d_cache_enable = 1'b1;
    repeat (2) @(negedge clk);
    d_cache_address = 20'h3FFFF; d_cache_write_or_read = 1'b1; d_cache_in_data = LINE_C;
    @(negedge clk);
    chk("hold mem_addr", 128'(mem_address), 128'(20'h00200));
    wait_ready(40, n);
    chk("hold ready", 128'(d_cache_ready), 128'(1));
    chk("hold stable", 128'(mem_changed), 128'(0));
    chk("hold dc_out", d_cache_out_data, LINE_A);
    $display("txn hold: dc read 00200 with address change, done");
    d_cache_enable = 1'b0;
    @(negedge clk);

    // Memory never answers: timeout after 255 BUSY cycles with an all-zero line.
    latency = 0; en_cycles = 0;
    i_cache_address = 20'h00777; i_cache_enable = 1'b1;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (n == 255) begin
        chk("tmo not yet", 128'(timeout_error), 128'(0));
        chk("tmo en high", 128'(mem_enable), 128'(1));
      end
      if (i_cache_ready || d_cache_ready) break;
    end
    chk("tmo ready at", 128'(n), 128'(256));
    chk("tmo ic_ready", 128'(i_cache_ready), 128'(1));
    chk("tmo flag", 128'(timeout_error), 128'(1));
    chk("tmo data", i_cache_out_data, '0);
    chk("tmo en cycles", 128'(en_cycles), 128'(255));
    $display("txn timeout: ic read 00777 completed after %0d cycles", n);
    i_cache_enable = 1'b0;
    @(negedge clk);
    v = mk(0, 20'h00321, '0, 0, 2, LINE_B, LINE_B, LINE_A);
    run_txn("after_tmo", v);
    chk("tmo sticky", 128'(timeout_error), 128'(1));

    // Reset in the middle of a transaction: outputs clear at once, no ready pulse.
    latency = 0;
    d_cache_address = 20'h00555; d_cache_write_or_read = 1'b0; d_cache_enable = 1'b1;
    repeat (3) @(negedge clk);
    ic_before = ic_pulses; dc_before = dc_pulses;
    reset = 1'b0;
    #1;
    chk("rst mem_enable", 128'(mem_enable), 128'(0));
    chk("rst mem_addr", 128'(mem_address), 128'(0));
    chk("rst outs", {i_cache_out_data | d_cache_out_data}, '0);
    chk("rst timeout", 128'(timeout_error), 128'(0));
    d_cache_enable = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst no pulse", 128'(ic_pulses + dc_pulses), 128'(ic_before + dc_before));
    v = mk(0, 20'h00ABC, '0, 0, 1, LINE_C, LINE_C, '0);
    run_txn("after_rst", v);
    chk("never both ready", 128'(both_high), 128'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
